// File: rtl/clock_trig_multi_pkg.sv
// Shared definitions for the multi-channel clock trigger: widths, channel state
// encoding and the per-channel configuration record latched at run start.
package clock_trig_multi_pkg;

    localparam int N_CH    = 4;
    localparam int GAP_W   = 32;
    localparam int WID_W   = 8;
    localparam int BURST_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } chan_state_e;

    typedef struct packed {
        logic [GAP_W-1:0]   gap;
        logic [GAP_W-1:0]   offset;
        logic [WID_W-1:0]   width;
        logic [BURST_W-1:0] burst;
    } chan_cfg_t;

endpackage

// File: rtl/clock_trig_multi_if.sv
// Configuration and trigger-output bundle between the run controller (master)
// and the trigger generator (slave).
interface clock_trig_multi_if;
    import clock_trig_multi_pkg::*;

    logic                    in_live;
    logic [N_CH-1:0]         ch_en;
    logic [N_CH*GAP_W-1:0]   user_gap;
    logic [N_CH*GAP_W-1:0]   user_offset;
    logic [N_CH*WID_W-1:0]   user_width;
    logic [N_CH*BURST_W-1:0] user_burst;
    logic [N_CH-1:0]         out;
    logic                    out_any;
    logic [N_CH*BURST_W-1:0] trig_cnt;
    logic [N_CH-1:0]         burst_done;

    modport master (
        output in_live, ch_en, user_gap, user_offset, user_width, user_burst,
        input  out, out_any, trig_cnt, burst_done
    );

    modport slave (
        input  in_live, ch_en, user_gap, user_offset, user_width, user_burst,
        output out, out_any, trig_cnt, burst_done
    );

endinterface

// File: rtl/clock_trig_multi_chan.sv
// One trigger channel: start delay, periodic phase counter, pulse-width stretcher
// and saturating pulse counter with optional finite burst.
module clock_trig_multi_chan
    import clock_trig_multi_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_live,
    input  logic               i_en,
    input  chan_cfg_t          i_cfg,
    output logic               o_out,
    output logic               o_out_nxt,
    output logic [BURST_W-1:0] o_trig_cnt,
    output logic               o_burst_done
);

    chan_state_e        r_state, w_state_nxt;
    chan_cfg_t          r_cfg, w_cfg;
    logic [GAP_W-1:0]   r_phase, w_phase_nxt;
    logic [WID_W-1:0]   r_wcnt, w_wcnt_nxt, w_wid_eff;
    logic [BURST_W-1:0] r_trig_cnt, w_trig_nxt;
    logic               r_out, r_burst_done, w_fire, w_out_nxt;

    // On the run-start edge the live inputs are used so an offset of 0 fires immediately.
    assign w_cfg     = (r_state == ST_IDLE) ? i_cfg : r_cfg;
    assign w_wid_eff = (w_cfg.width == '0) ? WID_W'(1) : w_cfg.width;

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_trig_nxt  = r_trig_cnt;
        w_wcnt_nxt  = r_wcnt;
        w_out_nxt   = 1'b0;
        w_fire      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_en) begin
                    if (w_cfg.offset == '0) begin
                        w_fire = 1'b1;
                    end else begin
                        w_state_nxt = ST_DELAY;
                        w_phase_nxt = GAP_W'(1);
                    end
                end
            end
            ST_DELAY: begin
                if (r_phase == w_cfg.offset) w_fire = 1'b1;
                else                         w_phase_nxt = r_phase + GAP_W'(1);
            end
            ST_RUN: begin
                if (r_phase == '0)             w_fire = 1'b1;
                else if (r_phase == w_cfg.gap) w_phase_nxt = '0;
                else                           w_phase_nxt = r_phase + GAP_W'(1);
            end
            default: ;
        endcase

        if (w_fire) begin
            w_state_nxt = ST_RUN;
            w_phase_nxt = (w_cfg.gap == '0) ? '0 : GAP_W'(1);
            if (r_trig_cnt != '1) w_trig_nxt = r_trig_cnt + BURST_W'(1);
            if (w_cfg.burst != '0 && w_trig_nxt == w_cfg.burst) w_state_nxt = ST_DONE;
            w_out_nxt  = 1'b1;
            w_wcnt_nxt = w_wid_eff - WID_W'(1);
        end else if (r_wcnt != '0) begin
            w_out_nxt  = 1'b1;
            w_wcnt_nxt = r_wcnt - WID_W'(1);
        end

        if (!i_live) begin
            w_state_nxt = ST_IDLE;
            w_phase_nxt = '0;
            w_trig_nxt  = '0;
            w_wcnt_nxt  = '0;
            w_out_nxt   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cfg        <= '0;
            r_phase      <= '0;
            r_wcnt       <= '0;
            r_trig_cnt   <= '0;
            r_out        <= 1'b0;
            r_burst_done <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && i_live) r_cfg <= i_cfg;
            r_state      <= w_state_nxt;
            r_phase      <= w_phase_nxt;
            r_wcnt       <= w_wcnt_nxt;
            r_trig_cnt   <= w_trig_nxt;
            r_out        <= w_out_nxt;
            r_burst_done <= (w_state_nxt == ST_DONE);
        end
    end

    assign o_out        = r_out;
    assign o_out_nxt    = w_out_nxt;
    assign o_trig_cnt   = r_trig_cnt;
    assign o_burst_done = r_burst_done;

endmodule

// File: rtl/clock_trig_multi.sv
// N-channel periodic trigger generator: independent channels plus a registered
// OR of all channel pulses aligned with the per-channel outputs.
module clock_trig_multi
    import clock_trig_multi_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    clock_trig_multi_if.slave  bus
);

    logic [N_CH-1:0]         w_out;
    logic [N_CH-1:0]         w_out_nxt;
    logic [N_CH-1:0]         w_burst_done;
    logic [N_CH*BURST_W-1:0] w_trig_cnt;
    logic                    r_out_any;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        chan_cfg_t w_cfg;

        assign w_cfg = '{
            gap:    bus.user_gap[c*GAP_W +: GAP_W],
            offset: bus.user_offset[c*GAP_W +: GAP_W],
            width:  bus.user_width[c*WID_W +: WID_W],
            burst:  bus.user_burst[c*BURST_W +: BURST_W]
        };

        clock_trig_multi_chan u_chan (
            .clk          (clk),
            .rst          (rst),
            .i_live       (bus.in_live),
            .i_en         (bus.ch_en[c]),
            .i_cfg        (w_cfg),
            .o_out        (w_out[c]),
            .o_out_nxt    (w_out_nxt[c]),
            .o_trig_cnt   (w_trig_cnt[c*BURST_W +: BURST_W]),
            .o_burst_done (w_burst_done[c])
        );
    end

    // Built from the next-state bits so out_any has no extra latency against out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_out_any <= 1'b0;
        else     r_out_any <= |w_out_nxt;
    end

    assign bus.out        = w_out;
    assign bus.out_any    = r_out_any;
    assign bus.trig_cnt   = w_trig_cnt;
    assign bus.burst_done = w_burst_done;

endmodule

// File: tb/tb_clock_trig_multi.sv
// Directed bench for clock_trig_multi: hand-computed per-cycle pulse tables for
// basic, offset/width, burst, corner and reset scenarios.
module tb_clock_trig_multi;
    import clock_trig_multi_pkg::*;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    clock_trig_multi_if bus ();

    clock_trig_multi dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle k of a run is sampled just after edge E0+k-1.
    // Run A: ch0 gap4/off0/wid1, ch1 gap9/off3/wid4, ch2 gap2/burst3, ch3 disabled.
    logic [3:0] exp_a [16] = '{
        4'b0101, 4'b0000, 4'b0000, 4'b0110, 4'b0010, 4'b0011, 4'b0110, 4'b0000,
        4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0011
    };
    // Run B: ch0 wid0/off1/gap3, ch1 gap4/wid20, ch2 gap0, ch3 gap0/off2/burst2.
    logic [3:0] exp_b [6] = '{
        4'b0110, 4'b0111, 4'b1110, 4'b1110, 4'b0110, 4'b0111
    };

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_ch(input int c, input logic [31:0] gap, input logic [31:0] off,
                          input logic [7:0] wid, input logic [15:0] burst, input logic en);
        bus.user_gap[c*GAP_W +: GAP_W]       = gap;
        bus.user_offset[c*GAP_W +: GAP_W]    = off;
        bus.user_width[c*WID_W +: WID_W]     = wid;
        bus.user_burst[c*BURST_W +: BURST_W] = burst;
        bus.ch_en[c]                         = en;
    endtask

    function automatic logic [15:0] cnt_of(input int c);
        return bus.trig_cnt[c*BURST_W +: BURST_W];
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_out"},   64'(bus.out), 64'd0);
        check({tag, "_any"},   64'(bus.out_any), 64'd0);
        check({tag, "_cnt"},   64'(bus.trig_cnt), 64'd0);
        check({tag, "_done"},  64'(bus.burst_done), 64'd0);
    endtask

    initial begin
        rst             = 1'b0;
        bus.in_live     = 1'b0;
        bus.ch_en       = '0;
        bus.user_gap    = '0;
        bus.user_offset = '0;
        bus.user_width  = '0;
        bus.user_burst  = '0;
        #1 rst = 1'b1;
        #2 check_idle("reset");
        step(2);
        rst = 1'b0;
        step(1);

        // Run A: basic period, offset/width, finite burst, disabled channel
        cfg_ch(0, 32'd4, 32'd0, 8'd1, 16'd0, 1'b1);
        cfg_ch(1, 32'd9, 32'd3, 8'd4, 16'd0, 1'b1);
        cfg_ch(2, 32'd2, 32'd0, 8'd1, 16'd3, 1'b1);
        cfg_ch(3, 32'd0, 32'd0, 8'd1, 16'd0, 1'b0);
        bus.in_live = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            check($sformatf("A_out_c%0d", k), 64'(bus.out), 64'(exp_a[k-1]));
            check($sformatf("A_any_c%0d", k), 64'(bus.out_any), 64'(|exp_a[k-1]));
            check($sformatf("A_done_c%0d", k), 64'(bus.burst_done),
                  (k >= 7) ? 64'h4 : 64'h0);
            if (k == 1)  check("A_cnt0_c1",  64'(cnt_of(0)), 64'd1);
            if (k == 6)  check("A_cnt0_c6",  64'(cnt_of(0)), 64'd2);
            if (k == 11) check("A_cnt0_c11", 64'(cnt_of(0)), 64'd3);
            // Mid-run reconfiguration must not take effect until the next run.
            if (k == 8)  bus.user_gap[0*GAP_W +: GAP_W] = 32'd1;
        end
        check("A_cnt_all", bus.trig_cnt, {16'd0, 16'd3, 16'd2, 16'd4});

        // Drop in_live while ch1 is mid-pulse
        bus.in_live = 1'b0;
        step(1);
        check_idle("A_drop");
        step(1);

        // Run B: width 0, width beyond period, gap 0, burst on gap 0 with offset
        cfg_ch(0, 32'd3, 32'd1, 8'd0,  16'd0, 1'b1);
        cfg_ch(1, 32'd4, 32'd0, 8'd20, 16'd0, 1'b1);
        cfg_ch(2, 32'd0, 32'd0, 8'd1,  16'd0, 1'b1);
        cfg_ch(3, 32'd0, 32'd2, 8'd1,  16'd2, 1'b1);
        bus.in_live = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            check($sformatf("B_out_c%0d", k), 64'(bus.out), 64'(exp_b[k-1]));
            check($sformatf("B_any_c%0d", k), 64'(bus.out_any), 64'(|exp_b[k-1]));
        end
        check("B_cnt1", 64'(cnt_of(1)), 64'd2);
        check("B_cnt2", 64'(cnt_of(2)), 64'd6);
        check("B_cnt3", 64'(cnt_of(3)), 64'd2);
        check("B_done", 64'(bus.burst_done), 64'h8);
        bus.in_live = 1'b0;
        step(1);
        check_idle("B_drop");
        step(1);

        // Run C: asynchronous reset in the middle of a pulse
        cfg_ch(0, 32'd9, 32'd0, 8'd3, 16'd0, 1'b1);
        cfg_ch(1, 32'd0, 32'd0, 8'd1, 16'd0, 1'b0);
        cfg_ch(2, 32'd0, 32'd0, 8'd1, 16'd0, 1'b0);
        cfg_ch(3, 32'd0, 32'd0, 8'd1, 16'd0, 1'b0);
        bus.in_live = 1'b1;
        step(2);
        check("C_pre_rst_out", 64'(bus.out), 64'h1);
        #2 rst = 1'b1;
        #1 check_idle("C_rst");
        step(1);
        rst = 1'b0;
        step(1);
        check("C_restart_out", 64'(bus.out), 64'h1);
        check("C_restart_cnt", 64'(cnt_of(0)), 64'd1);
        step(1);
        check("C_restart_c2", 64'(bus.out), 64'h1);
        bus.in_live = 1'b0;
        step(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
